// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: round-robin sharing of the AXI4 read channels (AR/R) between
// NREQ requesters onto one master read port. One burst outstanding at a time;
// R beats are routed back to the requester that won the AR grant.
// Optional build macro AXI_RD_ARB_CHECK_EN adds a beat counter and a sticky
// protocol error flag (err_o); without it err_o is constant 0.
module axi_rd_arbiter #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned AW   = 64,
    parameter int unsigned DW   = 64,
    parameter int unsigned IDW  = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NREQ-1:0]   s_arvalid_i,
    output logic [NREQ-1:0]   s_arready_o,
    input  logic [NREQ*AW-1:0] s_araddr_i,
    input  logic [NREQ*8-1:0] s_arlen_i,
    input  logic [NREQ*3-1:0] s_arsize_i,
    input  logic [NREQ*2-1:0] s_arburst_i,
    output logic [NREQ-1:0]   s_rvalid_o,
    input  logic [NREQ-1:0]   s_rready_i,
    output logic [DW-1:0]     s_rdata_o,
    output logic [1:0]        s_rresp_o,
    output logic              s_rlast_o,
    output logic [IDW-1:0]    M_AXI_ARID,
    output logic [AW-1:0]     M_AXI_ARADDR,
    output logic [7:0]        M_AXI_ARLEN,
    output logic [2:0]        M_AXI_ARSIZE,
    output logic [1:0]        M_AXI_ARBURST,
    output logic              M_AXI_ARVALID,
    input  logic              M_AXI_ARREADY,
    input  logic [IDW-1:0]    M_AXI_RID,
    input  logic [DW-1:0]     M_AXI_RDATA,
    input  logic [1:0]        M_AXI_RRESP,
    input  logic              M_AXI_RLAST,
    input  logic              M_AXI_RVALID,
    output logic              M_AXI_RREADY,
    output logic              err_o
);

    localparam int unsigned GW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

    state_e          state_q, state_d;
    logic [GW-1:0]   last_grant_q;
    logic [IDW-1:0]  arid_q;
    logic [AW-1:0]   araddr_q;
    logic [7:0]      arlen_q;
    logic [2:0]      arsize_q;
    logic [1:0]      arburst_q;
    logic            arvalid_q;

    logic            req_found;
    logic [GW-1:0]   req_idx;
    logic            ar_hs;
    logic            r_hs;

    // Round-robin search starting just after the previous winner.
    always_comb begin
        req_found = 1'b0;
        req_idx   = '0;
        for (int i = 1; i <= int'(NREQ); i++) begin
            if (!req_found && s_arvalid_i[(int'(last_grant_q) + i) % int'(NREQ)]) begin
                req_found = 1'b1;
                req_idx   = GW'((int'(last_grant_q) + i) % int'(NREQ));
            end
        end
    end

    // Reset gates the grant so a handshake is never offered while the registers are clearing.
    assign ar_hs = (state_q == StIdle) && req_found && !rst_i;
    assign r_hs  = (state_q == StData) && M_AXI_RVALID && M_AXI_RREADY;

    // Per-requester handshake/routing; R payload is shared and passed straight through.
    always_comb begin
        s_arready_o  = '0;
        s_rvalid_o   = '0;
        M_AXI_RREADY = 1'b0;
        if (ar_hs) begin
            s_arready_o[req_idx] = 1'b1;
        end
        if (state_q == StData) begin
            s_rvalid_o[last_grant_q] = M_AXI_RVALID;
            M_AXI_RREADY             = s_rready_i[last_grant_q];
        end
    end

    assign s_rdata_o = M_AXI_RDATA;
    assign s_rresp_o = M_AXI_RRESP;
    assign s_rlast_o = M_AXI_RLAST;

    // FSM next-state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (ar_hs) state_d = StAddr;
            StAddr:  if (M_AXI_ARREADY) state_d = StData;
            StData:  if (r_hs && M_AXI_RLAST) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // AR register slice: latch the winner's request, hold it until the slave accepts.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_grant_q <= GW'(NREQ - 1);
            arid_q       <= '0;
            araddr_q     <= '0;
            arlen_q      <= '0;
            arsize_q     <= '0;
            arburst_q    <= '0;
            arvalid_q    <= 1'b0;
        end else if (ar_hs) begin
            last_grant_q <= req_idx;
            arid_q       <= IDW'(req_idx);
            araddr_q     <= s_araddr_i[int'(req_idx)*AW +: AW];
            arlen_q      <= s_arlen_i[int'(req_idx)*8 +: 8];
            arsize_q     <= s_arsize_i[int'(req_idx)*3 +: 3];
            arburst_q    <= s_arburst_i[int'(req_idx)*2 +: 2];
            arvalid_q    <= 1'b1;
        end else if (state_q == StAddr && M_AXI_ARREADY) begin
            arvalid_q    <= 1'b0;
        end
    end

    assign M_AXI_ARID    = arid_q;
    assign M_AXI_ARADDR  = araddr_q;
    assign M_AXI_ARLEN   = arlen_q;
    assign M_AXI_ARSIZE  = arsize_q;
    assign M_AXI_ARBURST = arburst_q;
    assign M_AXI_ARVALID = arvalid_q;

`ifdef AXI_RD_ARB_CHECK_EN
    logic [7:0] beat_cnt_q;
    logic       err_q;

    // Beat counter and sticky error: RLAST position and RID are checked on every R handshake.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            beat_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            if (state_q == StAddr && M_AXI_ARREADY) begin
                beat_cnt_q <= '0;
            end else if (r_hs) begin
                beat_cnt_q <= beat_cnt_q + 8'd1;
            end
            if (r_hs && ((M_AXI_RLAST && beat_cnt_q != arlen_q) ||
                         (!M_AXI_RLAST && beat_cnt_q == arlen_q) ||
                         (M_AXI_RID != arid_q))) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err_o = err_q;
`else
    // RID is only consumed by the optional checker.
    logic unused_rid;
    assign unused_rid = ^M_AXI_RID;
    assign err_o      = 1'b0;
`endif

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Scoreboard bench for axi_rd_arbiter (NREQ=2). Stimulus pushes expected grants,
// AR transfers and R beats into queues; a negedge monitor pops and compares them
// whenever the DUT shows a handshake. Directed checks cover reset values and stability.
module tb_axi_rd_arbiter;

    localparam int NREQ = 2;
    localparam int AW   = 64;
    localparam int DW   = 64;
    localparam int IDW  = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NREQ-1:0]     s_arvalid = '0;
    logic [NREQ-1:0]     s_arready;
    logic [NREQ*AW-1:0]  s_araddr;
    logic [NREQ*8-1:0]   s_arlen;
    logic [NREQ*3-1:0]   s_arsize;
    logic [NREQ*2-1:0]   s_arburst;
    logic [NREQ-1:0]     s_rvalid;
    logic [NREQ-1:0]     s_rready = '0;
    logic [DW-1:0]       s_rdata;
    logic [1:0]          s_rresp;
    logic                s_rlast;
    logic [IDW-1:0]      m_arid;
    logic [AW-1:0]       m_araddr;
    logic [7:0]          m_arlen;
    logic [2:0]          m_arsize;
    logic [1:0]          m_arburst;
    logic                m_arvalid;
    logic                m_arready = 1'b0;
    logic [IDW-1:0]      m_rid = '0;
    logic [DW-1:0]       m_rdata = '0;
    logic [1:0]          m_rresp = 2'b00;
    logic                m_rlast = 1'b0;
    logic                m_rvalid = 1'b0;
    logic                m_rready;
    logic                err;

    logic [AW-1:0] req_addr [NREQ];
    logic [7:0]    req_len  [NREQ];

    assign s_araddr  = {req_addr[1], req_addr[0]};
    assign s_arlen   = {req_len[1], req_len[0]};
    assign s_arsize  = {3'd3, 3'd3};
    assign s_arburst = {2'b01, 2'b01};

    axi_rd_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .IDW(IDW)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .s_arvalid_i   (s_arvalid),
        .s_arready_o   (s_arready),
        .s_araddr_i    (s_araddr),
        .s_arlen_i     (s_arlen),
        .s_arsize_i    (s_arsize),
        .s_arburst_i   (s_arburst),
        .s_rvalid_o    (s_rvalid),
        .s_rready_i    (s_rready),
        .s_rdata_o     (s_rdata),
        .s_rresp_o     (s_rresp),
        .s_rlast_o     (s_rlast),
        .M_AXI_ARID    (m_arid),
        .M_AXI_ARADDR  (m_araddr),
        .M_AXI_ARLEN   (m_arlen),
        .M_AXI_ARSIZE  (m_arsize),
        .M_AXI_ARBURST (m_arburst),
        .M_AXI_ARVALID (m_arvalid),
        .M_AXI_ARREADY (m_arready),
        .M_AXI_RID     (m_rid),
        .M_AXI_RDATA   (m_rdata),
        .M_AXI_RRESP   (m_rresp),
        .M_AXI_RLAST   (m_rlast),
        .M_AXI_RVALID  (m_rvalid),
        .M_AXI_RREADY  (m_rready),
        .err_o         (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [AW-1:0]  addr;
        logic [7:0]     len;
    } ar_t;

    typedef struct packed {
        logic [NREQ-1:0] who;
        logic [DW-1:0]   data;
        logic            last;
    } r_t;

    ar_t             exp_ar_q [$];
    r_t              exp_r_q  [$];
    logic [NREQ-1:0] exp_g_q  [$];

    int   checks   = 0;
    int   failures = 0;
    logic err_exp  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pop and compare on every observed handshake.
    always @(negedge clk) begin
        ar_t             ea;
        r_t              er;
        logic [NREQ-1:0] eg;
        if ((s_arready & s_arvalid) != '0) begin
            if (exp_g_q.size() == 0) begin
                check("grant_unexpected", 64'(s_arready), 64'(0));
            end else begin
                eg = exp_g_q.pop_front();
                check("sb_grant", 64'(s_arready), 64'(eg));
            end
        end
        if (m_arvalid && m_arready) begin
            if (exp_ar_q.size() == 0) begin
                check("ar_unexpected", 64'(m_araddr), 64'(0));
            end else begin
                ea = exp_ar_q.pop_front();
                check("sb_arid", 64'(m_arid), 64'(ea.id));
                check("sb_araddr", m_araddr, ea.addr);
                check("sb_arlen", 64'(m_arlen), 64'(ea.len));
            end
        end
        if ((s_rvalid & s_rready) != '0) begin
            if (exp_r_q.size() == 0) begin
                check("r_unexpected", s_rdata, 64'(0));
            end else begin
                er = exp_r_q.pop_front();
                check("sb_r_who", 64'(s_rvalid), 64'(er.who));
                check("sb_rdata", s_rdata, er.data);
                check("sb_rlast", 64'(s_rlast), 64'(er.last));
            end
        end
    end

    // One burst from requester req; the bench plays the slave. rst_beat >= 0 asserts
    // reset while that beat is presented and abandons the burst.
    task automatic run_burst(input int req, input int len, input int last_at, input int ar_wait,
                             input int stall_beat, input int stall_n, input logic hold,
                             input logic [63:0] dbase, input int rst_beat);
        int          n;
        int          b;
        int          st;
        int          guard;
        int          top;
        logic        hs;
        logic [63:0] addr;
        addr         = req_addr[req];
        req_len[req] = 8'(len);
        s_arvalid[req] = 1'b1;
        exp_g_q.push_back(NREQ'(1 << req));
        exp_ar_q.push_back('{id: IDW'(req), addr: addr, len: 8'(len)});
        top = (rst_beat >= 0) ? rst_beat : last_at;
        for (int i = 0; i <= top; i++) begin
            exp_r_q.push_back('{who: NREQ'(1 << req), data: dbase + 64'(i), last: (i == last_at)});
        end
        #1;
        n = 0;
        while (((s_arready & s_arvalid) == '0) && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) begin
            check("grant_timeout", 64'(n), 64'(0));
            return;
        end
        check("arready_at_t", 64'(s_arready), 64'(1 << req));
        step();
        if (!hold) s_arvalid[req] = 1'b0;
        req_addr[req] = req_addr[req] + 64'h100;
        check("arvalid_t1", 64'(m_arvalid), 64'(1));
        check("arid_t1", 64'(m_arid), 64'(req));
        for (int w = 0; w < ar_wait; w++) begin
            check("arvalid_hold", 64'(m_arvalid), 64'(1));
            check("araddr_hold", m_araddr, addr);
            check("arlen_hold", 64'(m_arlen), 64'(len));
            check("no_arready_addr", 64'(s_arready), 64'(0));
            step();
        end
        m_arready = 1'b1;
        step();
        m_arready = 1'b0;
        b = 0;
        st = 0;
        guard = 0;
        while (b <= last_at && guard < 64) begin
            guard++;
            m_rvalid = 1'b1;
            m_rdata  = dbase + 64'(b);
            m_rlast  = (b == last_at);
            m_rid    = IDW'(req);
            if (b == stall_beat && st < stall_n) begin
                s_rready[req] = 1'b0;
                st++;
            end else begin
                s_rready[req] = 1'b1;
            end
            hs = s_rready[req];
            #1;
            check("rready_pass", 64'(m_rready), 64'(hs));
            check("rvalid_route", 64'(s_rvalid), 64'(1 << req));
            if (b == rst_beat) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
                m_rvalid = 1'b0;
                m_rlast = 1'b0;
                s_rready = '0;
                return;
            end
            step();
            if (hs) b++;
        end
        if (guard >= 64) check("beat_timeout", 64'(guard), 64'(0));
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        s_rready[req] = 1'b0;
        #1;
        check("rready_idle", 64'(m_rready), 64'(0));
        check("err_state", 64'(err), 64'(err_exp));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_arready"}, 64'(s_arready), 64'(0));
        check({tag, "_rvalid"}, 64'(s_rvalid), 64'(0));
        check({tag, "_arvalid"}, 64'(m_arvalid), 64'(0));
        check({tag, "_arid"}, 64'(m_arid), 64'(0));
        check({tag, "_araddr"}, m_araddr, 64'(0));
        check({tag, "_arlen"}, 64'(m_arlen), 64'(0));
        check({tag, "_rready"}, 64'(m_rready), 64'(0));
        check({tag, "_err"}, 64'(err), 64'(0));
    endtask

    initial begin
        req_addr[0] = 64'h8000_0000;
        req_addr[1] = 64'h9000_0000;
        req_len[0]  = 8'd0;
        req_len[1]  = 8'd0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
        check_reset_values("reset");

        // Single-beat read from requester 0.
        run_burst(0, 0, 0, 0, -1, 0, 1'b0, 64'hDEAD_BEEF, -1);

        // Both requesters hold arvalid: last winner was 0, so 1,0,1,0.
        s_arvalid = 2'b11;
        run_burst(1, 3, 3, 0, -1, 0, 1'b1, 64'h1000, -1);
        run_burst(0, 3, 3, 0, -1, 0, 1'b1, 64'h2000, -1);
        run_burst(1, 3, 3, 0, -1, 0, 1'b1, 64'h3000, -1);
        run_burst(0, 3, 3, 0, -1, 0, 1'b0, 64'h4000, -1);
        s_arvalid = 2'b00;

        // Slave stalls AR for 5 cycles.
        run_burst(0, 2, 2, 5, -1, 0, 1'b0, 64'h5000, -1);

        // Requester 1 backpressures R for 3 cycles mid-burst.
        run_burst(1, 3, 3, 0, 1, 3, 1'b0, 64'h6000, -1);

        // Early RLAST on the second beat of a len-3 burst.
`ifdef AXI_RD_ARB_CHECK_EN
        err_exp = 1'b1;
`endif
        run_burst(0, 3, 1, 0, -1, 0, 1'b0, 64'h7000, -1);
        run_burst(1, 1, 1, 0, -1, 0, 1'b0, 64'h8000, -1);

        // Reset during the second beat of a len-7 burst from requester 0.
        run_burst(0, 7, 7, 0, -1, 0, 1'b0, 64'h9000, 1);
        err_exp = 1'b0;
        check_reset_values("midreset");

        // After reset requester 0 wins again despite having been the last winner.
        s_arvalid = 2'b11;
        run_burst(0, 1, 1, 0, -1, 0, 1'b0, 64'hA000, -1);
        run_burst(1, 1, 1, 0, -1, 0, 1'b0, 64'hB000, -1);
        s_arvalid = 2'b00;

        step();
        step();
        check("sb_grant_empty", 64'(exp_g_q.size()), 64'(0));
        check("sb_ar_empty", 64'(exp_ar_q.size()), 64'(0));
        check("sb_r_empty", 64'(exp_r_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got %0t expected finish", $time);
        $fatal(1, "timeout");
    end

endmodule
